// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_sequencer
// Description : N-approach signal sequencer (all-red -> green -> yellow) with
//               demand skipping, busy extension, night flash, hold and police.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter  int NUM_PHASES = 4,
    parameter  int CNT_W      = 8,
    parameter  int GREEN_T    = 20,
    parameter  int YELLOW_T   = 3,
    parameter  int ALLRED_T   = 2,
    parameter  int EXT_T      = 10,
    localparam int IDX_W      = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  pause,
    input  logic [2:0]            mode,
    input  logic [NUM_PHASES-1:0] demand,
    input  logic [IDX_W-1:0]      hold_phase,
    input  logic                  police_step,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [IDX_W-1:0]      active_phase,
    output logic [CNT_W-1:0]      remaining,
    output logic [2:0]            state,
    output logic                  paused
);

    localparam logic [2:0] c_OFF    = 3'd0;
    localparam logic [2:0] c_ALLRED = 3'd1;
    localparam logic [2:0] c_GREEN  = 3'd2;
    localparam logic [2:0] c_YELLOW = 3'd3;
    localparam logic [2:0] c_FLASH  = 3'd4;

    localparam logic [2:0] c_MODE_ORD    = 3'd0;
    localparam logic [2:0] c_MODE_BUSY   = 3'd1;
    localparam logic [2:0] c_MODE_NIGHT  = 3'd2;
    localparam logic [2:0] c_MODE_HOLD   = 3'd3;
    localparam logic [2:0] c_MODE_POLICE = 3'd4;

    localparam int c_CNT_MAX  = (2 ** CNT_W) - 1;
    localparam int c_BUSY_SUM = GREEN_T + EXT_T;
    localparam logic [CNT_W-1:0] c_LD_GREEN  = CNT_W'((GREEN_T > c_CNT_MAX) ? c_CNT_MAX : GREEN_T);
    localparam logic [CNT_W-1:0] c_LD_BUSY   = CNT_W'((c_BUSY_SUM > c_CNT_MAX) ? c_CNT_MAX : c_BUSY_SUM);
    localparam logic [CNT_W-1:0] c_LD_YELLOW = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] c_LD_ALLRED = CNT_W'(ALLRED_T);
    localparam logic [IDX_W-1:0] c_LAST      = IDX_W'(NUM_PHASES - 1);

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_active;
    logic [CNT_W-1:0]      r_remaining;
    logic [NUM_PHASES-1:0] r_green, r_yellow, r_red;
    logic                  r_paused;
    logic                  r_flash;
    logic                  r_fresh;

    logic [2:0]            w_mode;
    logic [IDX_W-1:0]      w_hold_idx;
    logic                  w_expire;
    logic [IDX_W-1:0]      w_base, w_step1, w_search, w_probe, w_next;
    logic                  w_found;
    logic [CNT_W-1:0]      w_green_ld;
    logic [2:0]            w_nst;
    logic [IDX_W-1:0]      w_nact;
    logic [CNT_W-1:0]      w_nrem;
    logic                  w_nflash, w_nfresh;
    logic [NUM_PHASES-1:0] w_onehot, w_ngreen, w_nyellow, w_nred;

    assign w_mode     = (mode > c_MODE_POLICE) ? c_MODE_ORD : mode;
    assign w_hold_idx = (32'(hold_phase) < 32'(NUM_PHASES)) ? hold_phase : '0;
    assign w_expire   = tick && (r_remaining <= CNT_W'(1));

    // Until a green has been served after OFF, the search starts at phase 0.
    assign w_base  = r_fresh ? c_LAST : r_active;
    assign w_step1 = (w_base == c_LAST) ? '0 : w_base + 1'b1;

    always_comb begin
        w_search = w_step1;
        w_found  = 1'b0;
        w_probe  = '0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            w_probe = IDX_W'((32'(w_base) + 32'(k)) % NUM_PHASES);
            if (!w_found && demand[w_probe]) begin
                w_search = w_probe;
                w_found  = 1'b1;
            end
        end
    end

    assign w_next = (w_mode == c_MODE_HOLD)   ? w_hold_idx :
                    (w_mode == c_MODE_POLICE) ? w_step1    : w_search;
    assign w_green_ld = ((w_mode == c_MODE_BUSY) && demand[w_next]) ? c_LD_BUSY : c_LD_GREEN;

    always_comb begin
        w_nst    = r_state;
        w_nact   = r_active;
        w_nrem   = r_remaining;
        w_nflash = r_flash;
        w_nfresh = r_fresh;
        if (!enable) begin
            w_nst    = c_OFF;
            w_nact   = '0;
            w_nrem   = '0;
            w_nflash = 1'b0;
            w_nfresh = 1'b1;
        end else if (!pause) begin
            case (r_state)
                c_OFF: begin
                    w_nst  = c_ALLRED;
                    w_nrem = c_LD_ALLRED;
                end
                c_ALLRED: begin
                    if (w_expire) begin
                        if (w_mode == c_MODE_NIGHT) begin
                            // remaining reads 0 while flashing
                            w_nst    = c_FLASH;
                            w_nrem   = '0;
                            w_nflash = 1'b1;
                        end else begin
                            w_nst    = c_GREEN;
                            w_nact   = w_next;
                            w_nrem   = w_green_ld;
                            w_nfresh = 1'b0;
                        end
                    end else if (tick) begin
                        w_nrem = r_remaining - CNT_W'(1);
                    end
                end
                c_GREEN: begin
                    if (w_mode == c_MODE_HOLD) begin
                        if (w_hold_idx != r_active) begin
                            w_nst  = c_YELLOW;
                            w_nrem = c_LD_YELLOW;
                        end
                    end else if (w_mode == c_MODE_POLICE) begin
                        if (police_step) begin
                            w_nst  = c_YELLOW;
                            w_nrem = c_LD_YELLOW;
                        end
                    end else if (w_expire) begin
                        w_nst  = c_YELLOW;
                        w_nrem = c_LD_YELLOW;
                    end else if (tick) begin
                        w_nrem = r_remaining - CNT_W'(1);
                    end
                end
                c_YELLOW: begin
                    if (w_expire) begin
                        w_nst  = c_ALLRED;
                        w_nrem = c_LD_ALLRED;
                    end else if (tick) begin
                        w_nrem = r_remaining - CNT_W'(1);
                    end
                end
                c_FLASH: begin
                    if (w_mode != c_MODE_NIGHT) begin
                        w_nst  = c_ALLRED;
                        w_nrem = c_LD_ALLRED;
                    end else if (tick) begin
                        w_nflash = ~r_flash;
                    end
                end
                default: begin
                    w_nst = c_OFF;
                end
            endcase
        end
    end

    always_comb begin
        w_onehot         = '0;
        w_onehot[w_nact] = 1'b1;
        w_ngreen  = (w_nst == c_GREEN) ? w_onehot : '0;
        w_nyellow = (w_nst == c_YELLOW) ? w_onehot :
                    ((w_nst == c_FLASH) && w_nflash) ? '1 : '0;
        w_nred    = (w_nst == c_ALLRED) ? '1 :
                    ((w_nst == c_GREEN) || (w_nst == c_YELLOW)) ? ~w_onehot : '0;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= c_OFF;
            r_active    <= '0;
            r_remaining <= '0;
            r_green     <= '0;
            r_yellow    <= '0;
            r_red       <= '0;
            r_paused    <= 1'b0;
            r_flash     <= 1'b0;
            r_fresh     <= 1'b1;
        end else begin
            r_state     <= w_nst;
            r_active    <= w_nact;
            r_remaining <= w_nrem;
            r_green     <= w_ngreen;
            r_yellow    <= w_nyellow;
            r_red       <= w_nred;
            r_paused    <= enable && pause && (r_state != c_OFF);
            r_flash     <= w_nflash;
            r_fresh     <= w_nfresh;
        end
    end

    assign green        = r_green;
    assign yellow       = r_yellow;
    assign red          = r_red;
    assign active_phase = r_active;
    assign remaining    = r_remaining;
    assign state        = r_state;
    assign paused       = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_sequencer
// Description : Directed plus random bench for traffic_phase_sequencer
//               (default instance and a CNT_W=5/GREEN_T=25 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sequencer;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int YEL = 3;
    localparam int AR  = 2;
    localparam int EXT = 10;

    logic          clk = 1'b0;
    logic          Reset, tick, enable, pause, police_step;
    logic [2:0]    mode;
    logic [N-1:0]  demand;
    logic [IW-1:0] hold_phase;

    logic [N-1:0]  g0, y0, r0, g1, y1, r1;
    logic [IW-1:0] a0, a1;
    logic [7:0]    rem0;
    logic [4:0]    rem1;
    logic [2:0]    s0, s1;
    logic          p0, p1;

    traffic_phase_sequencer dut0 (
        .clk(clk), .Reset(Reset), .tick(tick), .enable(enable), .pause(pause),
        .mode(mode), .demand(demand), .hold_phase(hold_phase), .police_step(police_step),
        .green(g0), .yellow(y0), .red(r0), .active_phase(a0), .remaining(rem0),
        .state(s0), .paused(p0)
    );

    traffic_phase_sequencer #(.NUM_PHASES(4), .CNT_W(5), .GREEN_T(25)) dut1 (
        .clk(clk), .Reset(Reset), .tick(tick), .enable(enable), .pause(pause),
        .mode(mode), .demand(demand), .hold_phase(hold_phase), .police_step(police_step),
        .green(g1), .yellow(y1), .red(r1), .active_phase(a1), .remaining(rem1),
        .state(s1), .paused(p1)
    );

    always #5 clk = ~clk;

    // Reference model: stage 0 OFF, 1 ALLRED, 2 GREEN, 3 YELLOW, 4 FLASH
    int m_st[2], m_act[2], m_rem[2];
    bit m_fy[2], m_paused[2], m_served[2];
    int c_gt[2]  = '{20, 25};
    int c_max[2] = '{255, 31};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_act[i] = 0; m_rem[i] = 0;
            m_fy[i] = 0; m_paused[i] = 0; m_served[i] = 0;
        end
    endtask

    task automatic model_step();
        int md, h, prev, nxt, ld;
        bit expire;
        md = (mode > 3'd4) ? 0 : int'(mode);
        h  = int'(hold_phase);
        if (h >= N) h = 0;
        for (int i = 0; i < 2; i++) begin
            expire = tick && (m_rem[i] <= 1);
            if (!Reset) begin
                model_reset();
            end else if (!enable) begin
                m_st[i] = 0; m_act[i] = 0; m_rem[i] = 0;
                m_fy[i] = 0; m_paused[i] = 0; m_served[i] = 0;
            end else if (pause) begin
                m_paused[i] = (m_st[i] != 0);
            end else begin
                m_paused[i] = 0;
                case (m_st[i])
                    0: begin m_st[i] = 1; m_rem[i] = AR; end
                    1: if (expire) begin
                        if (md == 2) begin
                            m_st[i] = 4; m_rem[i] = 0; m_fy[i] = 1;
                        end else begin
                            prev = m_served[i] ? m_act[i] : N - 1;
                            nxt  = (prev + 1) % N;
                            if (md == 3) nxt = h;
                            else if (md != 4)
                                for (int k = N; k >= 1; k--)
                                    if (demand[IW'((prev + k) % N)]) nxt = (prev + k) % N;
                            ld = c_gt[i] + ((md == 1 && demand[IW'(nxt)]) ? EXT : 0);
                            m_st[i] = 2; m_act[i] = nxt; m_served[i] = 1;
                            m_rem[i] = (ld > c_max[i]) ? c_max[i] : ld;
                        end
                    end else if (tick) m_rem[i]--;
                    2: begin
                        if (md == 3) begin
                            if (h != m_act[i]) begin m_st[i] = 3; m_rem[i] = YEL; end
                        end else if (md == 4) begin
                            if (police_step) begin m_st[i] = 3; m_rem[i] = YEL; end
                        end else if (expire) begin
                            m_st[i] = 3; m_rem[i] = YEL;
                        end else if (tick) m_rem[i]--;
                    end
                    3: if (expire) begin m_st[i] = 1; m_rem[i] = AR; end
                       else if (tick) m_rem[i]--;
                    default: if (md != 2) begin m_st[i] = 1; m_rem[i] = AR; end
                             else if (tick) m_fy[i] = !m_fy[i];
                endcase
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [2:0] st, input logic [IW-1:0] act,
                             input logic [31:0] rem, input logic [N-1:0] g, input logic [N-1:0] y,
                             input logic [N-1:0] r, input logic pz);
        logic [N-1:0] sel, eg, ey, er;
        sel = N'(1) << m_act[i];
        eg  = (m_st[i] == 2) ? sel : '0;
        ey  = (m_st[i] == 3) ? sel : ((m_st[i] == 4) && m_fy[i]) ? '1 : '0;
        er  = (m_st[i] == 1) ? '1 : ((m_st[i] == 2) || (m_st[i] == 3)) ? ~sel : '0;
        chk($sformatf("d%0d_state", i), 32'(st), 32'(m_st[i]));
        chk($sformatf("d%0d_active", i), 32'(act), 32'(m_act[i]));
        chk($sformatf("d%0d_remaining", i), rem, 32'(m_rem[i]));
        chk($sformatf("d%0d_green", i), 32'(g), 32'(eg));
        chk($sformatf("d%0d_yellow", i), 32'(y), 32'(ey));
        chk($sformatf("d%0d_red", i), 32'(r), 32'(er));
        chk($sformatf("d%0d_paused", i), 32'(pz), 32'(m_paused[i]));
    endtask

    task automatic check_all();
        check_dut(0, s0, a0, 32'(rem0), g0, y0, r0, p0);
        check_dut(1, s1, a1, 32'(rem1), g1, y1, r1, p1);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic run_until(input int d, input logic [2:0] st, input int budget);
        int n = 0;
        while ((((d == 0) ? s0 : s1) !== st) && (n < budget)) begin
            cycle();
            n++;
        end
        chk($sformatf("d%0d_reach_state", d), 32'((d == 0) ? s0 : s1), 32'(st));
    endtask

    initial begin
        Reset = 1'b0; enable = 1'b0; pause = 1'b0; tick = 1'b0; police_step = 1'b0;
        mode = 3'd0; demand = '0; hold_phase = '0;
        model_reset();
        #3;
        check_all();
        chk("rst_state", 32'(s0), 32'd0);
        cycle();
        cycle();
        Reset = 1'b1;
        cycle();
        chk("off_idle", 32'(s0), 32'd0);

        // Ordinary cycle with all demand
        enable = 1'b1; demand = 4'b1111; tick = 1'b1;
        cycle();
        chk("allred_enter", 32'(s0), 32'd1);
        chk("allred_rem", 32'(rem0), 32'd2);
        cycle();
        cycle();
        chk("green0_state", 32'(s0), 32'd2);
        chk("green0_phase", 32'(a0), 32'd0);
        chk("green0_rem", 32'(rem0), 32'd20);
        chk("green0_lamps", 32'(g0), 32'h1);
        chk("green0_red", 32'(r0), 32'he);
        repeat (19) cycle();
        chk("green0_last", 32'(s0), 32'd2);
        cycle();
        chk("yellow_state", 32'(s0), 32'd3);
        chk("yellow_rem", 32'(rem0), 32'd3);
        chk("yellow_lamp", 32'(y0), 32'h1);
        repeat (3) cycle();
        chk("allred2_state", 32'(s0), 32'd1);
        repeat (2) cycle();
        chk("green1_phase", 32'(a0), 32'd1);

        // Demand skipping
        demand = 4'b0100;
        run_until(0, 3'd3, 100);
        run_until(0, 3'd2, 100);
        chk("skip_to_2", 32'(a0), 32'd2);
        demand = 4'b0000;
        run_until(0, 3'd3, 100);
        run_until(0, 3'd2, 100);
        chk("no_demand_next", 32'(a0), 32'd3);

        // Busy extension and saturation
        mode = 3'd1; demand = 4'b1111;
        run_until(0, 3'd3, 100);
        run_until(0, 3'd2, 100);
        chk("busy_ext_rem", 32'(rem0), 32'd30);
        run_until(1, 3'd3, 100);
        run_until(1, 3'd2, 100);
        chk("busy_sat_rem", 32'(rem1), 32'd31);

        // Night flash
        run_until(0, 3'd2, 100);
        mode = 3'd2;
        cycle();
        chk("night_keeps_green", 32'(s0), 32'd2);
        run_until(0, 3'd3, 100);
        run_until(0, 3'd1, 100);
        run_until(0, 3'd4, 100);
        chk("flash_on", 32'(y0), 32'hf);
        chk("flash_green_off", 32'(g0 | r0), 32'h0);
        cycle();
        chk("flash_toggle_off", 32'(y0), 32'h0);
        cycle();
        chk("flash_toggle_on", 32'(y0), 32'hf);
        mode = 3'd0; demand = 4'b0001;
        cycle();
        chk("flash_exit", 32'(s0), 32'd1);

        // Hold
        run_until(0, 3'd2, 100);
        chk("hold_start_p0", 32'(a0), 32'd0);
        mode = 3'd3; hold_phase = 2'd2;
        cycle();
        chk("hold_mismatch", 32'(s0), 32'd3);
        run_until(0, 3'd2, 100);
        chk("hold_phase2", 32'(a0), 32'd2);
        chk("hold_rem", 32'(rem0), 32'd20);
        repeat (5) cycle();
        chk("hold_frozen", 32'(rem0), 32'd20);

        // Police
        mode = 3'd4;
        repeat (3) cycle();
        chk("police_frozen", 32'(rem0), 32'd20);
        police_step = 1'b1;
        cycle();
        police_step = 1'b0;
        chk("police_step", 32'(s0), 32'd3);
        run_until(0, 3'd2, 100);
        chk("police_next", 32'(a0), 32'd3);

        // Pause
        mode = 3'd0;
        cycle();
        chk("pre_pause_rem", 32'(rem0), 32'd19);
        pause = 1'b1;
        repeat (10) cycle();
        chk("pause_rem", 32'(rem0), 32'd19);
        chk("pause_green", 32'(g0), 32'h8);
        chk("pause_flag", 32'(p0), 32'd1);
        pause = 1'b0;
        cycle();
        chk("unpause_rem", 32'(rem0), 32'd18);

        // Asynchronous reset mid-yellow
        run_until(0, 3'd3, 100);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_yellow", 32'(y0 | r0 | g0), 32'h0);
        cycle();
        Reset = 1'b1;
        cycle();
        chk("rst_release", 32'(s0), 32'd1);
        enable = 1'b0;
        cycle();
        chk("disable_off", 32'(s0), 32'd0);
        enable = 1'b1;

        // Random soak against the model
        for (int c = 0; c < 3000; c++) begin
            tick        = 1'($urandom_range(0, 1));
            pause       = ($urandom_range(0, 11) == 0);
            police_step = ($urandom_range(0, 7) == 0);
            enable      = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 29) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) hold_phase = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) demand = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised N-approach traffic signal sequencer: drives green/yellow/red lamps for `NUM_PHASES` approaches through an all-red → green → yellow cycle with per-stage second-based timers. It implements demand-skipping, peak-hour green extension, a night flashing mode, an online hold mode, police manual stepping and pause. It sits below the top-level mode controller, which supplies `mode`, `enable` and `pause`, and above the lamp/display drivers.

## Interface
Parameters:
- `NUM_PHASES`, 4, number of approaches (2..8); `IDX_W` = max(1, clog2(`NUM_PHASES`)), derived.
- `CNT_W`, 8, timer width in ticks.
- `GREEN_T`, 20, green duration in ticks (≥1).
- `YELLOW_T`, 3, yellow duration in ticks (≥1).
- `ALLRED_T`, 2, all-red clearance in ticks (≥1).
- `EXT_T`, 10, extra green in BUSY mode.

Ports (one clock; `Reset` is asynchronous, active-low):
- `clk` in 1: system clock.
- `Reset` in 1: asynchronous active-low reset.
- `tick` in 1: one-cycle timebase pulse (1 s).
- `enable` in 1: power/run; 0 forces OFF.
- `pause` in 1: freeze state and timer.
- `mode` in 3: 0 ORD, 1 BUSY, 2 NIGHT, 3 HOLD, 4 POLICE; 5–7 behave as ORD.
- `demand` in NUM_PHASES: vehicle present per approach.
- `hold_phase` in IDX_W: approach held green in HOLD; values ≥ NUM_PHASES read as 0.
- `police_step` in 1: one-cycle pulse, ends current green in POLICE.
- `green`, `yellow`, `red` out NUM_PHASES each: lamp drives.
- `active_phase` out IDX_W: current approach.
- `remaining` out CNT_W: ticks left in current stage.
- `state` out 3: 0 OFF, 1 ALLRED, 2 GREEN, 3 YELLOW, 4 FLASH.
- `paused` out 1: registered copy of `pause` while not OFF.

## Operation
- All outputs registered. While `Reset`=0, every output is 0 and `state`=OFF.
- Priority per cycle: `enable`=0 → OFF; else `pause`=1 → hold everything; else state logic.
- OFF: lamps 0, `remaining`=0, `active_phase`=0. If `enable`=1, go to ALLRED and load ALLRED_T.
- Timer: on `tick`, if `remaining` ≤ 1 the stage expires (next stage loads); otherwise decrement. Each stage therefore lasts exactly its load value in ticks.
- ALLRED: `red` all 1. On expiry:
  - mode NIGHT → FLASH.
  - mode HOLD → GREEN at `hold_phase`.
  - otherwise → GREEN at the next phase: cyclic search from `active_phase`+1 for the first set `demand` bit, with the current phase checked last. If `demand`=0, use `active_phase`+1 mod NUM_PHASES. POLICE always uses `active_phase`+1 mod N.
- GREEN: `green[active]`=1, others red.
  - Load GREEN_T. In BUSY with `demand[active]`=1 at load, load GREEN_T+EXT_T, saturating at 2^CNT_W−1.
  - Expiry → YELLOW.
  - HOLD: timer frozen while `hold_phase`==`active_phase`. On mismatch, go to YELLOW next cycle regardless of `tick`.
  - POLICE: timer frozen. `police_step` → YELLOW next cycle.
  - Entering NIGHT during GREEN does not cut green short.
- YELLOW: `yellow[active]`=1, others red, load YELLOW_T. Expiry → ALLRED.
- FLASH: `green` and `red` all 0. `yellow` is all-1 on entry and inverts on every `tick`. When mode ≠ NIGHT → ALLRED next cycle, `active_phase` unchanged.
- `police_step` outside POLICE+GREEN is ignored. A mode change takes effect only at the points listed above.

## Timing
- `enable` 0→1: `state`=ALLRED on the next clock edge. `enable`=0: OFF on the next edge, all lamps 0.
- Lamps, `state`, `active_phase` and `remaining` update on the same edge.
- `tick` coincident with `pause` is dropped. `tick` coincident with `police_step` or a HOLD mismatch: the exit wins and the tick is not applied.
- `Reset` asserted mid-operation clears outputs asynchronously. Release returns to OFF.

## Test plan
- Reset, `enable`=1, ORD, `demand`=4'b1111, `tick` every cycle → ALLRED 2, GREEN phase 0 for 20 ticks, YELLOW 3, ALLRED 2, then GREEN phase 1.
- In GREEN phase 0 with `demand`=4'b0100 → next green is phase 2. With `demand`=0 → next green is phase 1.
- BUSY, `demand[1]`=1 at green load → `remaining`=30. With CNT_W=5 and GREEN_T=25 → `remaining`=31 (saturated).
- NIGHT set during GREEN → green runs out, YELLOW, ALLRED, then FLASH with `yellow` toggling 4'b1111/4'b0000 each tick. Mode back to ORD → ALLRED next cycle.
- HOLD, `hold_phase`=2, in GREEN phase 0 → YELLOW next cycle, later GREEN phase 2 with `remaining` frozen at 20. POLICE with `police_step` → YELLOW next cycle.
- `pause`=1 for 10 ticks in GREEN → `remaining` and lamps unchanged. `Reset`=0 mid-YELLOW → all outputs 0 immediately.
